// File: rtl/chesssoc_spi_slave.sv
// SPI mode-0 responder with a CPU register port. All SPI pins are
// oversampled into clk; SCLK is never used as a clock.
module chesssoc_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_select,
  input  logic [2:0]  mem_addr,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe
);

  localparam logic [15:0] CTRL_MASK = 16'h01D8;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

  state_t r_state, w_state_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
  logic r_sclk_d, r_ss_d, r_settled, r_ss_armed, r_rd0_d;
  logic [7:0]  r_tx_holding, r_shift_reg, r_rx_shift, r_rx_holding;
  logic        r_tx_primed, r_rrdy, r_roe, r_tur;
  logic [2:0]  r_bitcnt;
  logic [15:0] r_ctrl;

  logic w_sclk_s, w_ss_s, w_mosi_s;
  logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
  logic w_load, w_rise_act, w_fall_shift, w_byte_done;
  logic w_wr, w_tx_wr, w_stat_wr, w_ctrl_wr, w_rd0, w_rd0_pulse;
  logic [15:0] w_status;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_ss_fall   = ~w_ss_s & r_ss_d;
  assign w_ss_rise   = w_ss_s & ~r_ss_d;

  assign w_wr        = spi_select & ~write_n;
  assign w_tx_wr     = w_wr & (mem_addr == 3'd1);
  assign w_stat_wr   = w_wr & (mem_addr == 3'd2);
  assign w_ctrl_wr   = w_wr & (mem_addr == 3'd3);
  assign w_rd0       = spi_select & ~read_n & (mem_addr == 3'd0);
  assign w_rd0_pulse = w_rd0 & ~r_rd0_d;
  assign w_byte_done = w_rise_act & (r_bitcnt == 3'd7);

  assign w_status = {6'b0, ~w_ss_s, r_roe | r_tur, r_rrdy, ~r_tx_primed,
                     1'b0, r_tur, r_roe, 3'b0};

  assign MISO    = r_shift_reg[7];
  assign MISO_oe = ~w_ss_s;

  // Synchronisers reset to the idle bus (SCLK low, SS_n high).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
      r_settled   <= 1'b0;
      r_ss_armed  <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sclk_d    <= w_sclk_s;
      r_ss_d      <= w_ss_s;
      r_settled   <= 1'b1;
      // A frame already running at reset release is ignored until SS_n is seen high.
      r_ss_armed  <= r_ss_armed | (r_settled & r_ss_sync[0]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_rise_act   = 1'b0;
    w_fall_shift = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ss_fall && r_ss_armed) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_load       = 1'b1;
        w_state_next = w_ss_rise ? ST_IDLE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_ss_rise) begin
          w_state_next = ST_IDLE;
        end else begin
          w_rise_act = w_sclk_rise;
          if (w_sclk_fall) begin
            if (r_bitcnt == 3'd0) w_load = 1'b1;
            else                  w_fall_shift = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_holding <= '0;
      r_tx_primed  <= 1'b0;
      r_shift_reg  <= '0;
      r_rx_shift   <= '0;
      r_rx_holding <= '0;
      r_bitcnt     <= '0;
      r_rrdy       <= 1'b0;
      r_roe        <= 1'b0;
      r_tur        <= 1'b0;
      r_ctrl       <= '0;
      r_rd0_d      <= 1'b0;
      data_to_cpu  <= '0;
      irq          <= 1'b0;
    end else begin
      r_rd0_d <= w_rd0;
      if (w_tx_wr) r_tx_holding <= data_from_cpu[7:0];
      // A CPU write in the same cycle as a load survives as the next byte.
      if (w_tx_wr)     r_tx_primed <= 1'b1;
      else if (w_load) r_tx_primed <= 1'b0;

      if (w_load)            r_shift_reg <= r_tx_primed ? r_tx_holding : 8'h00;
      else if (w_fall_shift) r_shift_reg <= {r_shift_reg[6:0], 1'b0};

      if (w_load)          r_bitcnt <= '0;
      else if (w_rise_act) r_bitcnt <= r_bitcnt + 3'd1;

      if (w_rise_act) r_rx_shift <= {r_rx_shift[6:0], w_mosi_s};
      if (w_byte_done) r_rx_holding <= {r_rx_shift[6:0], w_mosi_s};

      if (w_byte_done)      r_rrdy <= 1'b1;
      else if (w_rd0_pulse) r_rrdy <= 1'b0;

      if (w_byte_done && r_rrdy && !w_rd0_pulse) r_roe <= 1'b1;
      else if (w_stat_wr)                       r_roe <= 1'b0;

      if (w_load && !r_tx_primed) r_tur <= 1'b1;
      else if (w_stat_wr)         r_tur <= 1'b0;

      if (w_ctrl_wr) r_ctrl <= data_from_cpu & CTRL_MASK;

      case (mem_addr)
        3'd0:    data_to_cpu <= {8'h00, r_rx_holding};
        3'd2:    data_to_cpu <= w_status;
        3'd3:    data_to_cpu <= r_ctrl;
        default: data_to_cpu <= '0;
      endcase

      irq <= ((r_roe | r_tur) & r_ctrl[8]) | (r_rrdy & r_ctrl[7]) |
             (~r_tx_primed & r_ctrl[6]) | (r_tur & r_ctrl[4]) | (r_roe & r_ctrl[3]);
    end
  end

endmodule

// File: tb/tb_chesssoc_spi_slave.sv
// Bench for chesssoc_spi_slave: a mode-0 SPI master plus a CPU driver,
// checked against a transaction-level model of the slave's registers.
module tb_chesssoc_spi_slave;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        spi_select;
  logic [2:0]  mem_addr;
  logic        read_n;
  logic        write_n;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        irq;
  logic        SCLK;
  logic        SS_n;
  logic        MOSI;
  logic        MISO;
  logic        MISO_oe;

  chesssoc_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .spi_select(spi_select), .mem_addr(mem_addr),
    .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .irq(irq), .SCLK(SCLK), .SS_n(SS_n),
    .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int quiet = 0;
  logic [25:0] last_snap = '0;
  logic in_frame = 1'b0;

  // Slave state as seen by the CPU and the master
  logic [7:0]  m_txh, m_rx;
  logic        m_prim, m_rrdy, m_roe, m_tur;
  logic [15:0] m_ctrl;

  logic [7:0] f_mosi [4];
  logic       f_wr_en [4];
  logic [7:0] f_wr_val [4];
  logic [7:0] f_got [4];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic mdl_reset();
    m_txh = 8'h00; m_rx = 8'h00; m_prim = 1'b0; m_rrdy = 1'b0;
    m_roe = 1'b0; m_tur = 1'b0; m_ctrl = 16'h0000;
  endtask

  // Each byte slot takes the primed TX byte, or sends zero and flags underrun.
  task automatic consume(output logic [7:0] b);
    if (m_prim) begin
      b = m_txh;
      m_prim = 1'b0;
    end else begin
      b = 8'h00;
      m_tur = 1'b1;
    end
  endtask

  task automatic rx_done(input logic [7:0] b);
    if (m_rrdy) m_roe = 1'b1;
    m_rrdy = 1'b1;
    m_rx = b;
  endtask

  function automatic logic [15:0] mdl_status();
    return {6'b0, ~SS_n, m_roe | m_tur, m_rrdy, ~m_prim, 1'b0, m_tur, m_roe, 3'b0};
  endfunction

  function automatic logic [15:0] mdl_read(input logic [2:0] a);
    case (a)
      3'd0:    return {8'h00, m_rx};
      3'd2:    return mdl_status();
      3'd3:    return m_ctrl;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic mdl_irq();
    return ((m_roe | m_tur) & m_ctrl[8]) | (m_rrdy & m_ctrl[7]) | (~m_prim & m_ctrl[6]) |
           (m_tur & m_ctrl[4]) | (m_roe & m_ctrl[3]);
  endfunction

  // One clk cycle; outputs are compared with the model once inputs have been still a while.
  task automatic tick();
    logic [25:0] snap;
    @(negedge clk);
    #2;
    snap = {reset_n, SCLK, SS_n, MOSI, spi_select, read_n, write_n, mem_addr, data_from_cpu};
    if (snap === last_snap) quiet++;
    else begin
      quiet = 0;
      last_snap = snap;
    end
    if (quiet >= 6 && !in_frame && reset_n) begin
      chk("idle_dout", data_to_cpu, mdl_read(mem_addr));
      chk("idle_irq", {15'b0, irq}, {15'b0, mdl_irq()});
      chk("idle_oe", {15'b0, MISO_oe}, {15'b0, ~SS_n});
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
    case (a)
      3'd1: begin m_txh = d[7:0]; m_prim = 1'b1; end
      3'd2: begin m_roe = 1'b0; m_tur = 1'b0; end
      3'd3: m_ctrl = d & 16'h01D8;
      default: ;
    endcase
    $display("wr addr=%0d data=%h", a, d);
    tick();
    spi_select = 1'b0; write_n = 1'b1; mem_addr = 3'd2; data_from_cpu = 16'h0000;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
    tick();
    d = data_to_cpu;
    chk("cpu_read", d, mdl_read(a));
    $display("rd addr=%0d data=%h", a, d);
    if (a == 3'd0) m_rrdy = 1'b0;
    spi_select = 1'b0; read_n = 1'b1; mem_addr = 3'd2;
  endtask

  // Master: SCLK = clk/10, MOSI set on the low phase, MISO sampled at the rising edge.
  task automatic run_frame(input int nbytes, input int partial_bits);
    logic [7:0] exp_b, got_b;
    in_frame = 1'b1;
    SS_n = 1'b0;
    repeat (3) tick();
    consume(exp_b);
    if (partial_bits > 0) begin
      for (int b = 0; b < partial_bits; b++) begin
        MOSI = 1'($urandom);
        repeat (5) tick();
        SCLK = 1'b1;
        repeat (5) tick();
        SCLK = 1'b0;
      end
      $display("spi partial frame bits=%0d", partial_bits);
    end else begin
      for (int i = 0; i < nbytes; i++) begin
        got_b = 8'h00;
        for (int b = 7; b >= 0; b--) begin
          MOSI = f_mosi[i][b];
          repeat (5) tick();
          got_b[b] = MISO;
          SCLK = 1'b1;
          if (b == 4 && f_wr_en[i]) begin
            cpu_write(3'd1, {8'h00, f_wr_val[i]});
            repeat (4) tick();
          end else begin
            repeat (5) tick();
          end
          SCLK = 1'b0;
        end
        rx_done(f_mosi[i]);
        f_got[i] = got_b;
        chk("miso_byte", {8'h00, got_b}, {8'h00, exp_b});
        $display("spi byte %0d mosi=%h miso=%h", i, f_mosi[i], got_b);
        consume(exp_b);
      end
    end
    repeat (5) tick();
    SS_n = 1'b1;
    MOSI = 1'b0;
    in_frame = 1'b0;
    repeat (2) tick();
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 4; i++) begin
      f_mosi[i] = 8'h00; f_wr_en[i] = 1'b0; f_wr_val[i] = 8'h00; f_got[i] = 8'h00;
    end
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  tmp8;
    reset_n = 1'b0; spi_select = 1'b0; mem_addr = 3'd2; read_n = 1'b1; write_n = 1'b1;
    data_from_cpu = 16'h0000; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    mdl_reset();
    clear_frame();
    repeat (3) @(negedge clk);
    #2;
    chk("rst_dout", data_to_cpu, 16'h0000);
    chk("rst_irq", {15'b0, irq}, 16'h0000);
    chk("rst_miso", {15'b0, MISO}, 16'h0000);
    chk("rst_oe", {15'b0, MISO_oe}, 16'h0000);
    reset_n = 1'b1;
    repeat (4) tick();

    // 1: primed TX byte goes out while 0x3C comes in
    cpu_write(3'd1, 16'h00A5);
    f_mosi[0] = 8'h3C;
    run_frame(1, 0);
    chk("t1_miso", {8'h00, f_got[0]}, 16'h00A5);
    repeat (8) tick();
    cpu_read(3'd2, d); chk("t1_status", d, 16'h01D0);
    cpu_read(3'd0, d); chk("t1_rx", d, 16'h003C);
    cpu_read(3'd2, d); chk("t1_status_after", d, 16'h0150);

    // 2: underrun with its interrupt enabled
    cpu_write(3'd2, 16'h0000);
    cpu_write(3'd3, 16'h0010);
    f_mosi[0] = 8'h81;
    run_frame(1, 0);
    chk("t2_miso", {8'h00, f_got[0]}, 16'h0000);
    repeat (8) tick();
    chk("t2_irq_set", {15'b0, irq}, 16'h0001);
    cpu_read(3'd2, d); chk("t2_status", d, 16'h01D0);
    cpu_write(3'd2, 16'h0000);
    repeat (6) tick();
    chk("t2_irq_clr", {15'b0, irq}, 16'h0000);

    // 3: overrun from two unread bytes
    cpu_read(3'd0, d); chk("t3_pre_rx", d, 16'h0081);
    f_mosi[0] = 8'h11; f_mosi[1] = 8'h22;
    run_frame(2, 0);
    repeat (8) tick();
    cpu_read(3'd2, d); chk("t3_status", d, 16'h01D8);
    cpu_read(3'd0, d); chk("t3_rx", d, 16'h0022);

    // 4: aborted frame leaves the RX side untouched
    cpu_write(3'd2, 16'h0000);
    run_frame(1, 5);
    repeat (8) tick();
    cpu_read(3'd2, d); chk("t4_status", d, 16'h0150);
    cpu_read(3'd0, d); chk("t4_rx_kept", d, 16'h0022);
    f_mosi[0] = 8'h5A;
    run_frame(1, 0);
    repeat (8) tick();
    cpu_read(3'd0, d); chk("t4_rx", d, 16'h005A);

    // 5: TX refilled between back-to-back bytes
    cpu_write(3'd2, 16'h0000);
    cpu_write(3'd1, 16'h00F0);
    f_mosi[0] = 8'h12; f_mosi[1] = 8'h34;
    f_wr_en[0] = 1'b1; f_wr_val[0] = 8'h0F;
    f_wr_en[1] = 1'b1; f_wr_val[1] = 8'h77;
    run_frame(2, 0);
    chk("t5_miso0", {8'h00, f_got[0]}, 16'h00F0);
    chk("t5_miso1", {8'h00, f_got[1]}, 16'h000F);
    repeat (8) tick();
    cpu_read(3'd2, d); chk("t5_tur", {15'b0, d[4]}, 16'h0000);
    clear_frame();

    // 6: reset in the middle of a frame
    cpu_read(3'd0, d);
    cpu_write(3'd2, 16'h0000);
    cpu_write(3'd3, 16'h0040);
    in_frame = 1'b1;
    SS_n = 1'b0;
    repeat (3) tick();
    consume(tmp8);
    for (int b = 0; b < 3; b++) begin
      MOSI = 1'b1; repeat (5) tick(); SCLK = 1'b1; repeat (5) tick(); SCLK = 1'b0;
    end
    repeat (2) tick();
    #3 reset_n = 1'b0;
    mdl_reset();
    #1;
    chk("t6_rst_dout", data_to_cpu, 16'h0000);
    chk("t6_rst_irq", {15'b0, irq}, 16'h0000);
    chk("t6_rst_miso", {15'b0, MISO}, 16'h0000);
    chk("t6_rst_oe", {15'b0, MISO_oe}, 16'h0000);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    cpu_write(3'd1, 16'h0099);
    for (int b = 3; b < 8; b++) begin
      MOSI = 1'b1; repeat (5) tick(); SCLK = 1'b1; repeat (5) tick(); SCLK = 1'b0;
    end
    repeat (5) tick();
    SS_n = 1'b1; MOSI = 1'b0;
    in_frame = 1'b0;
    repeat (8) tick();
    cpu_read(3'd2, d); chk("t6_status", d, 16'h0000);
    f_mosi[0] = 8'hC3;
    run_frame(1, 0);
    chk("t6_miso", {8'h00, f_got[0]}, 16'h0099);
    repeat (8) tick();
    cpu_read(3'd0, d); chk("t6_rx", d, 16'h00C3);

    // Randomised traffic against the model
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 1) cpu_write(3'd1, 16'($urandom));
      if ($urandom_range(0, 3) == 0) cpu_write(3'd3, 16'($urandom));
      for (int i = 0; i < 4; i++) begin
        f_mosi[i] = 8'($urandom);
        f_wr_en[i] = 1'($urandom);
        f_wr_val[i] = 8'($urandom);
      end
      if ($urandom_range(0, 4) == 0) run_frame(1, int'($urandom_range(1, 7)));
      else run_frame(int'($urandom_range(1, 3)), 0);
      repeat (8) tick();
      cpu_read(3'($urandom_range(0, 7)), d);
      if ($urandom_range(0, 2) == 0) cpu_read(3'd0, d);
      if ($urandom_range(0, 2) == 0) cpu_write(3'd2, 16'($urandom));
      if ($urandom_range(0, 1) == 1) cpu_write(3'($urandom_range(4, 7)), 16'($urandom));
      repeat (8) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
